// File: rtl/textmode_cm_ctrl_if.sv
// Character-memory controller bus bundle.
// Renderer, host, command, status and memory signals.
interface textmode_cm_ctrl_if #(
  parameter int ADDRW = 12
) ();
  logic             ren_req;
  logic [ADDRW-1:0] ren_addr;
  logic             ren_rvalid;
  logic [7:0]       ren_rdata;
  logic             host_valid;
  logic             host_ready;
  logic [ADDRW-1:0] host_addr;
  logic [7:0]       host_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             cmd_done;
  logic             busy;
  logic             host_err;
  logic [ADDRW-1:0] cm_addr_read;
  logic [7:0]       cm_rdata;
  logic             cm_we;
  logic [ADDRW-1:0] cm_addr_write;
  logic [7:0]       cm_wdata;

  modport slave (
    input  ren_req, ren_addr,
    output ren_rvalid, ren_rdata,
    input  host_valid, host_addr, host_data,
    output host_ready,
    input  cmd_valid, cmd_op,
    output cmd_ready, cmd_done,
    output busy, host_err,
    output cm_addr_read, cm_we,
    output cm_addr_write, cm_wdata,
    input  cm_rdata
  );

  modport master (
    output ren_req, ren_addr,
    input  ren_rvalid, ren_rdata,
    output host_valid, host_addr, host_data,
    input  host_ready,
    output cmd_valid, cmd_op,
    input  cmd_ready, cmd_done,
    input  busy, host_err,
    input  cm_addr_read, cm_we,
    input  cm_addr_write, cm_wdata,
    output cm_rdata
  );
endinterface

// File: rtl/textmode_cm_ctrl.sv
// Text-mode character memory arbiter + clear/scroll engine.
// Scroll/fill engine built only with TEXTMODE_CM_SCROLL_EN.
module textmode_cm_ctrl #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         ADDRW     = $clog2(COLS*ROWS)
) (
  input logic clk_sys,
  input logic rst_sys_n,
  textmode_cm_ctrl_if.slave bus
);

  localparam int NCELL = COLS * ROWS;
  localparam logic [ADDRW-1:0] LAST =
    ADDRW'(NCELL - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLEAR  = 2'd1;
  localparam logic [1:0] SCROLL = 2'd2;
  localparam logic [1:0] FILL   = 2'd3;

  logic [1:0]       state;
  logic [ADDRW-1:0] wptr;
  logic             cm_we;
  logic [ADDRW-1:0] cm_addr_write;
  logic [7:0]       cm_wdata;
  logic [ADDRW-1:0] cm_addr_read;
  logic             cmd_done;
  logic             host_err;
  logic             rq1;
  logic             ren_rvalid;
  logic             host_acc;
  logic             cmd_acc;

  assign bus.host_ready = (state == IDLE);
  assign bus.cmd_ready  = (state == IDLE) &&
                          !bus.host_valid;
  assign host_acc = bus.host_valid && bus.host_ready;
  assign cmd_acc  = bus.cmd_valid && bus.cmd_ready;

  assign bus.busy          = (state != IDLE);
  assign bus.ren_rdata     = bus.cm_rdata;
  assign bus.ren_rvalid    = ren_rvalid;
  assign bus.cm_we         = cm_we;
  assign bus.cm_addr_write = cm_addr_write;
  assign bus.cm_wdata      = cm_wdata;
  assign bus.cm_addr_read  = cm_addr_read;
  assign bus.cmd_done      = cmd_done;
  assign bus.host_err      = host_err;

`ifdef TEXTMODE_CM_SCROLL_EN
  localparam logic [ADDRW-1:0] COLS_A =
    ADDRW'(COLS);
  localparam logic [ADDRW-1:0] COPY_LAST =
    ADDRW'(NCELL - COLS - 1);

  logic [ADDRW-1:0] rd_ptr;
  logic [ADDRW-1:0] rd_nxt;
  logic             rd_act;
  logic             rd_go;
  logic             srd_v;
  logic             srd_v1;

  // Engine wants the read slot: accept edge or copy phase.
  always_comb begin
    rd_go  = 1'b0;
    rd_nxt = rd_ptr;
    if (state == IDLE && cmd_acc && bus.cmd_op) begin
      rd_go  = 1'b1;
      rd_nxt = COLS_A;
    end else if (state == SCROLL && rd_act) begin
      rd_go  = 1'b1;
    end
  end
`endif

  // Read port: renderer always wins, engine takes idle slots.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      cm_addr_read <= '0;
      rq1          <= 1'b0;
      ren_rvalid   <= 1'b0;
`ifdef TEXTMODE_CM_SCROLL_EN
      rd_ptr <= '0;
      rd_act <= 1'b0;
      srd_v  <= 1'b0;
      srd_v1 <= 1'b0;
`endif
    end else begin
      rq1        <= bus.ren_req;
      ren_rvalid <= rq1;
      if (bus.ren_req) begin
        cm_addr_read <= bus.ren_addr;
      end
`ifdef TEXTMODE_CM_SCROLL_EN
      else if (rd_go) begin
        cm_addr_read <= rd_nxt;
      end
      srd_v  <= rd_go && !bus.ren_req;
      srd_v1 <= srd_v;
      if (rd_go) begin
        if (bus.ren_req) begin
          rd_ptr <= rd_nxt;
          rd_act <= 1'b1;
        end else begin
          rd_ptr <= rd_nxt + ADDRW'(1);
          rd_act <= (rd_nxt != LAST);
        end
      end
`endif
    end
  end

  // Write port, FSM and completion/status flags.
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      state         <= IDLE;
      wptr          <= '0;
      cm_we         <= 1'b0;
      cm_addr_write <= '0;
      cm_wdata      <= '0;
      cmd_done      <= 1'b0;
      host_err      <= 1'b0;
    end else begin
      cm_we    <= 1'b0;
      cmd_done <= 1'b0;
      unique case (1'b1)
        (state == IDLE): begin
          if (host_acc) begin
            cm_addr_write <= bus.host_addr;
            cm_wdata      <= bus.host_data;
            if (bus.host_addr > LAST) begin
              host_err <= 1'b1;
            end else begin
              cm_we <= 1'b1;
            end
          end else if (cmd_acc) begin
            if (!bus.cmd_op) begin
              state         <= CLEAR;
              cm_we         <= 1'b1;
              cm_addr_write <= '0;
              cm_wdata      <= FILL_CHAR;
              wptr          <= ADDRW'(1);
            end else begin
              state <= SCROLL;
`ifdef TEXTMODE_CM_SCROLL_EN
              wptr  <= '0;
`else
              cmd_done <= 1'b1;
`endif
            end
          end
        end
        (state == CLEAR): begin
          if (cm_addr_write == LAST) begin
            state    <= IDLE;
            cmd_done <= 1'b1;
          end else begin
            cm_we         <= 1'b1;
            cm_addr_write <= wptr;
            wptr          <= wptr + ADDRW'(1);
          end
        end
`ifdef TEXTMODE_CM_SCROLL_EN
        (state == SCROLL): begin
          if (srd_v1) begin
            cm_we         <= 1'b1;
            cm_addr_write <= wptr;
            cm_wdata      <= bus.cm_rdata;
            wptr          <= wptr + ADDRW'(1);
            if (wptr == COPY_LAST) begin
              state <= FILL;
            end
          end
        end
        (state == FILL): begin
          if (cm_addr_write == LAST) begin
            state    <= IDLE;
            cmd_done <= 1'b1;
          end else begin
            cm_we         <= 1'b1;
            cm_addr_write <= wptr;
            cm_wdata      <= FILL_CHAR;
            wptr          <= wptr + ADDRW'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_textmode_cm_ctrl.sv
// Self-checking bench for textmode_cm_ctrl.
// Scroll checks depend on TEXTMODE_CM_SCROLL_EN.
module tb_textmode_cm_ctrl;

  logic clk_sys = 1'b0;
  logic rst_sys_n;
  always #5 clk_sys = ~clk_sys;

  textmode_cm_ctrl_if bus ();

  textmode_cm_ctrl dut (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:4095];
  logic       mem_init = 1'b0;

  // Simple dual-port BRAM, 1-cycle registered read.
  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int a = 0; a < 4096; a++) mem[a] <= 8'(a);
    end else if (bus.cm_we) begin
      mem[bus.cm_addr_write] <= bus.cm_wdata;
    end
    bus.cm_rdata <= mem[bus.cm_addr_read];
  end

  logic        rq1 = 1'b0, rq2 = 1'b0;
  logic [11:0] ra1 = '0, ra2 = '0;
  logic        data_chk = 1'b0;
  bit          rq_at [0:2599];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock; renderer latency-2 expectations ride along.
  task automatic tick();
    logic        r0;
    logic [11:0] a0;
    logic        rs;
    r0 = bus.ren_req;
    a0 = bus.ren_addr;
    rs = rst_sys_n;
    @(posedge clk_sys);
    #1;
    if (!rs) begin
      rq1 = 1'b0;
      rq2 = 1'b0;
    end else begin
      rq2 = rq1;
      ra2 = ra1;
      rq1 = r0;
      ra1 = a0;
    end
    if (rq1) chk("ren_addr", 32'(bus.cm_addr_read), 32'(ra1));
    chk("ren_rvalid", 32'(bus.ren_rvalid), 32'(rq2));
    if (rq2 && data_chk)
      chk("ren_rdata", 32'(bus.ren_rdata), 32'(ra2[7:0]));
  endtask

  function automatic logic [31:0] outs0();
    return 32'({bus.cm_we, bus.cmd_done, bus.busy,
                bus.host_err, bus.ren_rvalid,
                bus.cm_addr_read, bus.cm_addr_write,
                bus.cm_wdata});
  endfunction

  initial begin
    int errs;
    int t;
    int done_t;
    int cnt;
    int o;
    logic [7:0] e;

    rst_sys_n      = 1'b0;
    bus.ren_req    = 1'b0;
    bus.ren_addr   = '0;
    bus.host_valid = 1'b0;
    bus.host_addr  = '0;
    bus.host_data  = '0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      bus.ren_req    = 1'($urandom);
      bus.ren_addr   = 12'($urandom);
      bus.host_valid = 1'($urandom);
      bus.host_addr  = 12'($urandom);
      bus.host_data  = 8'($urandom);
      bus.cmd_valid  = 1'($urandom);
      bus.cmd_op     = 1'($urandom);
      tick();
      chk("rst_outs", outs0(), 32'd0);
    end
    bus.ren_req    = 1'b0;
    bus.host_valid = 1'b0;
    bus.cmd_valid  = 1'b0;
    rst_sys_n      = 1'b1;
    #1;
    chk("rst_host_ready", 32'(bus.host_ready), 32'd1);
    tick();
    chk("post_rst_outs", outs0(), 32'd0);

    // Host writes incl. out-of-range address
    bus.host_valid = 1'b1;
    bus.host_addr  = 12'd5;
    bus.host_data  = 8'h41;
    #1;
    chk("hw_ready", 32'(bus.host_ready), 32'd1);
    chk("hw_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.host_addr = 12'd2400;
    bus.host_data = 8'hA5;
    chk("hw_write5", 32'({bus.cm_we, bus.cm_addr_write,
        bus.cm_wdata, bus.host_err}),
        32'({1'b1, 12'd5, 8'h41, 1'b0}));
    tick();
    bus.host_addr = 12'd2399;
    bus.host_data = 8'h3C;
    chk("hw_oob", 32'({bus.cm_we, bus.host_err}), 32'b01);
    tick();
    bus.host_valid = 1'b0;
    chk("hw_last", 32'({bus.cm_we, bus.cm_addr_write,
        bus.cm_wdata, bus.host_err}),
        32'({1'b1, 12'd2399, 8'h3C, 1'b1}));
    tick();
    chk("hw_err_sticky", 32'({bus.cm_we, bus.host_err}),
        32'b01);

    // Host and clear command together: host first
    bus.host_valid = 1'b1;
    bus.host_addr  = 12'd7;
    bus.host_data  = 8'h99;
    bus.cmd_valid  = 1'b1;
    bus.cmd_op     = 1'b0;
    #1;
    chk("sim_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    tick();
    bus.host_valid = 1'b0;
    #1;
    chk("sim_host_wr", 32'({bus.cm_we, bus.cm_addr_write,
        bus.cm_wdata}), 32'({1'b1, 12'd7, 8'h99}));
    chk("sim_cmd_acc", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 2400; k++) begin
      chk("clr_wr", 32'({bus.cm_we, bus.cm_addr_write,
          bus.cm_wdata, bus.busy, bus.host_ready,
          bus.cmd_done}),
          32'({1'b1, 12'(k - 1), 8'h20, 3'b100}));
      bus.ren_req  = 1'($urandom);
      bus.ren_addr = 12'($urandom_range(0, 2399));
      tick();
    end
    bus.ren_req = 1'b0;
    chk("clr_done", 32'({bus.cmd_done, bus.busy,
        bus.host_ready, bus.cm_we}), 32'b1010);
    tick();
    chk("clr_done_pulse", 32'(bus.cmd_done), 32'd0);
    errs = 0;
    for (int a = 0; a < 2400; a++)
      if (mem[a] !== 8'h20) errs++;
    chk("clr_mem", 32'(errs), 32'd0);

`ifdef TEXTMODE_CM_SCROLL_EN
    // Scroll with 10 renderer stalls in the copy phase
    mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    cnt = 0;
    while (cnt < 10) begin
      o = int'($urandom_range(1, 2300));
      if (!rq_at[o]) begin
        rq_at[o] = 1'b1;
        cnt++;
      end
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    #1;
    chk("scr_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("scr_first_rd", 32'({bus.busy, bus.cm_addr_read}),
        32'({1'b1, 12'd80}));
    data_chk = 1'b1;
    t = 1;
    done_t = 0;
    while (t < 2600 && done_t == 0) begin
      if (bus.cmd_done) begin
        done_t = t;
      end else begin
        if (t == 3)
          chk("scr_first_wr", 32'({bus.cm_we,
              bus.cm_addr_write, bus.cm_wdata}),
              32'({1'b1, 12'd0, 8'h50}));
        bus.ren_req  = rq_at[t];
        bus.ren_addr = 12'(2320 + $urandom_range(0, 79));
        tick();
        t++;
      end
    end
    data_chk = 1'b0;
    bus.ren_req = 1'b0;
    chk("scr_done_t", 32'(done_t), 32'd2413);
    chk("scr_idle", 32'({bus.busy, bus.host_ready}), 32'b01);
    errs = 0;
    for (int a = 0; a < 2400; a++) begin
      e = (a < 2320) ? 8'(a + 80) : 8'h20;
      if (mem[a] !== e) errs++;
    end
    chk("scr_mem", 32'(errs), 32'd0);
    bus.cmd_op = 1'b1;
`else
    // Scroll stub: one busy cycle, done pulse, no access
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 1'b1;
    #1;
    chk("stub_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("stub_a1", 32'({bus.busy, bus.cmd_done, bus.cm_we}),
        32'b110);
    tick();
    chk("stub_a2", 32'({bus.busy, bus.cmd_done, bus.cm_we,
        bus.host_ready}), 32'b0001);
    bus.cmd_op = 1'b0;
`endif

    // Reset 1000 cycles into a long command
    tick();
    bus.cmd_valid = 1'b1;
    #1;
    chk("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 1; i < 1000; i++) tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst_sys_n = 1'b0;
    tick();
    rst_sys_n = 1'b1;
    chk("mid_abort", 32'({bus.busy, bus.cm_we, bus.cmd_done,
        bus.host_err, bus.host_ready}), 32'b00001);
    errs = 0;
    for (int i = 0; i < 2500; i++) begin
      tick();
      if (bus.cm_we !== 1'b0 || bus.cmd_done !== 1'b0 ||
          bus.busy !== 1'b0)
        errs++;
    end
    chk("mid_quiet", 32'(errs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
